fc_frame_sequencer: RTL and testbench

//  Sequences one fully-connected classification pass per frame. Accepts a feature frame as a

---
 rtl/fc_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fc_frame_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_frame_sequencer.sv
// fc_frame_sequencer: one FC classification pass per feature frame.
// Optional watchdog: define FC_SEQ_TIMEOUT_EN.
module fc_frame_sequencer #(
  parameter int DATA_BITS   = 8,
  parameter int CHANNEL_LEN = 3,
  parameter int BEATS       = 16,
  parameter int DRAIN_CYC   = 2,
  parameter int FRAME_W     = 16,
  parameter int TIMEOUT     = 255,
  localparam int IDX_W      = $clog2(BEATS),
  localparam int BW         = CHANNEL_LEN*DATA_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BW-1:0]      s_data,
  input  logic               s_last,
  output logic               dp_clr,
  output logic               dp_val,
  output logic [BW-1:0]      dp_data,
  output logic [IDX_W-1:0]   dp_idx,
  input  logic [3:0]         dp_decision,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [3:0]         m_decision,
  output logic [FRAME_W-1:0] m_frame,
  output logic               busy,
  output logic               err_len,
  output logic               err_timeout
);

  localparam int DW = $clog2(DRAIN_CYC+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_beat;
  logic [DW-1:0]      r_drain;
  logic               r_dp_val;
  logic [BW-1:0]      r_dp_data;
  logic [IDX_W-1:0]   r_dp_idx;
  logic               r_m_valid;
  logic [3:0]         r_m_dec;
  logic [FRAME_W-1:0] r_m_frame;
  logic               r_err_len;

  logic w_hs;
  logic w_last_beat;
  logic w_early;
  logic w_drain_done;
  logic w_tmo;

  assign w_hs         = s_valid & s_ready;
  assign w_last_beat  = (r_beat == IDX_W'(BEATS-1));
  assign w_early      = w_hs & s_last & ~w_last_beat;
  assign w_drain_done = (r_state == S_DRAIN) &&
                        (r_drain == DW'(DRAIN_CYC));

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] r_idle;
  logic          r_err_tmo;

  assign w_tmo = (r_state == S_ACC) & ~w_hs &
                 (r_idle == TW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle    <= '0;
      r_err_tmo <= 1'b0;
    end else if (r_state == S_CLR) begin
      r_idle    <= '0;
      r_err_tmo <= 1'b0;
    end else if (r_state == S_ACC) begin
      if (w_hs) begin
        r_idle <= '0;
      end else if (w_tmo) begin
        r_idle    <= '0;
        r_err_tmo <= 1'b1;
      end else begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end

  assign err_timeout = r_err_tmo;
`else
  assign w_tmo       = 1'b0;
  // no watchdog in this build: flag is constant low
  assign err_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (s_valid) w_next = S_CLR;
      end
      S_CLR: begin
        w_next = S_ACC;
      end
      S_ACC: begin
        if (w_early) begin
          w_next = S_IDLE;
        end else if (w_hs && w_last_beat) begin
          w_next = S_DRAIN;
        end else if (w_tmo) begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) w_next = S_OUT;
      end
      S_OUT: begin
        if (m_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= '0;
      r_drain   <= '0;
      r_dp_val  <= 1'b0;
      r_dp_data <= '0;
      r_dp_idx  <= '0;
      r_m_valid <= 1'b0;
      r_m_dec   <= '0;
      r_m_frame <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_dp_val <= 1'b0;
      if (r_state == S_CLR) begin
        r_beat    <= '0;
        r_drain   <= '0;
        r_err_len <= 1'b0;
      end
      if (w_hs) begin
        r_dp_val  <= 1'b1;
        r_dp_data <= s_data;
        r_dp_idx  <= r_beat;
        r_beat    <= r_beat + IDX_W'(1);
        // misplaced or missing s_last both flag the frame
        if (s_last ^ w_last_beat) r_err_len <= 1'b1;
      end
      if (r_state == S_DRAIN) begin
        if (w_drain_done) begin
          r_drain   <= '0;
          r_m_dec   <= dp_decision;
          r_m_valid <= 1'b1;
        end else begin
          r_drain <= r_drain + DW'(1);
        end
      end
      if ((r_state == S_OUT) && m_ready) begin
        r_m_valid <= 1'b0;
        r_m_frame <= r_m_frame + FRAME_W'(1);
      end
    end
  end

  assign s_ready    = (r_state == S_ACC);
  assign dp_clr     = (r_state == S_CLR);
  assign busy       = (r_state != S_IDLE);
  assign dp_val     = r_dp_val;
  assign dp_data    = r_dp_data;
  assign dp_idx     = r_dp_idx;
  assign m_valid    = r_m_valid;
  assign m_decision = r_m_dec;
  assign m_frame    = r_m_frame;
  assign err_len    = r_err_len;

endmodule

// File: tb/tb_fc_frame_sequencer.sv
// Bench for fc_frame_sequencer: random frames vs. a frame-level model.
// Watchdog checks are enabled when FC_SEQ_TIMEOUT_EN is defined.
module tb_fc_frame_sequencer;

  localparam int DB    = 8;
  localparam int CL    = 3;
  localparam int BEATS = 16;
  localparam int DRAIN = 2;
  localparam int FW    = 16;
`ifdef FC_SEQ_TIMEOUT_EN
  localparam int TMO   = 8;
`else
  localparam int TMO   = 255;
`endif
  localparam int IW    = $clog2(BEATS);
  localparam int BW    = DB*CL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          dp_clr;
  logic          dp_val;
  logic [BW-1:0] dp_data;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_decision = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [3:0]    m_decision;
  logic [FW-1:0] m_frame;
  logic          busy;
  logic          err_len;
  logic          err_timeout;

  fc_frame_sequencer #(
    .DATA_BITS(DB), .CHANNEL_LEN(CL), .BEATS(BEATS),
    .DRAIN_CYC(DRAIN), .FRAME_W(FW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .dp_clr(dp_clr), .dp_val(dp_val),
    .dp_data(dp_data), .dp_idx(dp_idx),
    .dp_decision(dp_decision),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_decision(m_decision), .m_frame(m_frame),
    .busy(busy), .err_len(err_len),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] d;
    logic [IW-1:0] i;
  } beat_t;

  typedef struct {
    logic [3:0]    dec;
    logic [FW-1:0] fr;
  } res_t;

  beat_t bq[$];
  res_t  rq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int last_dp_cyc = 0;
  int res_cnt = 0;
  int force_hold = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  // result acceptor: random m_ready, random hold once m_valid rises
  initial begin : acceptor
    int  hold;
    bit  seen;
    hold = 0;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid && !seen) begin
        seen = 1;
        hold = (force_hold > 0) ? force_hold : $urandom_range(0, 6);
        force_hold = 0;
      end
      if (!m_valid) begin
        seen = 0;
        m_ready = 1'($urandom_range(0, 1));
      end else if (hold > 0) begin
        m_ready = 1'b0;
        hold--;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  logic       mv_prev = 1'b0;
  logic       hs_prev = 1'b0;
  logic [3:0] dec_prev = '0;
  logic [FW-1:0] fr_prev = '0;

  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    if (!rst_n) begin
      mv_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (dp_clr) clr_cnt++;
      if (dp_val) begin
        if (bq.size() == 0) begin
          chk("dp_spurious", 1, 0);
        end else begin
          b = bq.pop_front();
          chk("dp_data", dp_data, b.d);
          chk("dp_idx", dp_idx, b.i);
        end
        if (dp_idx == IW'(BEATS-1)) last_dp_cyc = cyc;
      end
      if (m_valid) begin
        chk("out_s_ready", s_ready, 0);
        chk("out_dp_clr", dp_clr, 0);
        if (!mv_prev) begin
          chk("latency", cyc - last_dp_cyc, DRAIN + 1);
        end else if (!hs_prev) begin
          chk("hold_dec", m_decision, dec_prev);
          chk("hold_frame", m_frame, fr_prev);
        end
        if (m_ready) begin
          if (rq.size() == 0) begin
            chk("res_spurious", 1, 0);
          end else begin
            r = rq.pop_front();
            chk("m_decision", m_decision, r.dec);
            chk("m_frame", m_frame, r.fr);
          end
        end
      end
      mv_prev  = m_valid;
      hs_prev  = m_valid & m_ready;
      dec_prev = m_decision;
      fr_prev  = m_frame;
    end
  end

  task automatic put_beat(input logic [BW-1:0] d, input logic l,
                          input int gap, input int idx);
    int    t;
    beat_t b;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      chk("beat_accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    b.d = d;
    b.i = IW'(idx);
    bq.push_back(b);
    @(posedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(nm, busy, 0);
  endtask

  // last_pos >= BEATS means no s_last at all; gapmax < 0 means
  // alternating valid (one idle cycle between beats)
  task automatic send_frame(input int last_pos, input int gapmax,
                            input int stall_after, input int stall_len,
                            input logic [3:0] dec);
    int   nb;
    int   c0;
    int   g;
    bit   abort;
    res_t r;
    dp_decision = dec;
    abort = (last_pos < BEATS-1);
    nb = abort ? last_pos + 1 : BEATS;
    c0 = clr_cnt;
    if (!abort) begin
      r.dec = dec;
      r.fr  = FW'(res_cnt);
      rq.push_back(r);
      res_cnt++;
    end
    for (int i = 0; i < nb; i++) begin
      if (i == 0) g = 0;
      else if (i == stall_after + 1) g = stall_len;
      else if (gapmax < 0) g = 1;
      else g = $urandom_range(0, gapmax);
      put_beat(BW'($urandom), 1'(i == last_pos), g, i);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("err_len", err_len, 64'(last_pos != BEATS-1));
    chk("err_timeout", err_timeout, 0);
    if (abort) chk("abort_busy", busy, 0);
    wait_idle("frame_idle");
    chk("clr_per_frame", clr_cnt - c0, 1);
    chk("m_frame_idle", m_frame, FW'(res_cnt));
  endtask

  task automatic rand_frame();
    int   p;
    int   lp;
    p = $urandom_range(0, 9);
    if (p == 0) lp = $urandom_range(0, BEATS-2);
    else if (p == 1) lp = 99;
    else lp = BEATS-1;
    send_frame(lp, 3, -5, 0, 4'($urandom));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_dp_clr"}, dp_clr, 0);
    chk({nm, "_dp_val"}, dp_val, 0);
    chk({nm, "_dp_data"}, dp_data, 0);
    chk({nm, "_dp_idx"}, dp_idx, 0);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_decision"}, m_decision, 0);
    chk({nm, "_m_frame"}, m_frame, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err_len"}, err_len, 0);
    chk({nm, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin : stim
    int c0;
    int stall;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // back-to-back frame, decision 7, result held 10 cycles
    force_hold = 10;
    send_frame(BEATS-1, 0, -5, 0, 4'd7);
    // alternating valid
    send_frame(BEATS-1, -1, -5, 0, 4'd3);
    // early s_last on beat 5
    send_frame(5, 1, -5, 0, 4'd9);
    // missing s_last: flagged but completes
    send_frame(99, 2, -5, 0, 4'd12);
`ifdef FC_SEQ_TIMEOUT_EN
    stall = TMO - 1;
`else
    stall = 300;
`endif
    // long stall inside the frame just short of any watchdog
    send_frame(BEATS-1, 1, 7, stall, 4'd5);

`ifdef FC_SEQ_TIMEOUT_EN
    c0 = clr_cnt;
    dp_decision = 4'd2;
    for (int i = 0; i < 4; i++) put_beat(BW'($urandom), 1'b0, 0, i);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_busy_before", busy, 1);
    chk("tmo_flag_before", err_timeout, 0);
    @(negedge clk);
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_m_frame", m_frame, FW'(res_cnt));
    chk("tmo_clr", clr_cnt - c0, 1);
`endif

    for (int k = 0; k < 20; k++) rand_frame();

    // asynchronous reset in the middle of a frame
    dp_decision = 4'd6;
    for (int i = 0; i < 7; i++) put_beat(BW'($urandom), 1'b0, 0, i);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bq.delete();
    res_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_idle", busy, 0);

    send_frame(BEATS-1, 2, -5, 0, 4'd11);
    for (int k = 0; k < 4; k++) rand_frame();

    repeat (20) @(negedge clk);
    chk("res_queue_empty", rq.size(), 0);
    chk("beat_queue_empty", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
